vliw_fetch_unit: RTL
====================

Name: vliw_fetch_unit

Overview:
Fetch stage directly upstream of the slot decoder/control unit. Issues bundle reads to instruction memory, buffers up to two returned 64-bit bundles, and presents each bundle split into the R-slot and S-slot instruction words and their 5-bit opcodes. Handles branch/jump redirects by flushing the buffer and discarding stale in-flight responses. Also handles halt requests raised on decode exceptions.

Parameters:
AW, 32, instruction address width (byte address)
RESET_PC, 0, fetch address after reset (bits [2:0] must be 0)
DEPTH, 2, bundle buffer entries; also the maximum number of outstanding plus buffered bundles

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  synchronous active-low reset
imem_req  output  1  request valid (combinational)
imem_addr  output  AW  request byte address (= pc)
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  response valid; responses return in order, latency >= 1 cycle
imem_rdata  input  64  bundle: [63:32] R-slot, [31:0] S-slot
dec_ready  input  1  decoder consumes head bundle
bundle_valid  output  1  head bundle valid
bundle_pc  output  AW  address of head bundle
r_instr  output  32  head R-slot word
s_instr  output  32  head S-slot word
R_opcode  output  5  r_instr[31:27]
S_opcode  output  5  s_instr[31:27]
redirect  input  1  branch/jump taken
redirect_pc  input  AW  new fetch address
halt  input  1  stop fetching (from exception)
halted  output  1  unit is in HALT state

Behaviour:
- Reset (reset_n low at an edge) has priority over all other inputs:
  - pc = RESET_PC, state RUN, buffer empty, outstanding = 0, drop_cnt = 0.
  - bundle_valid = 0, halted = 0.
  - imem_req is 0 during the reset cycle.
  - Reset mid-transaction: responses for pre-reset requests are not dropped by the unit. The memory is also reset and must not return them.
- Credits: imem_req = (state == RUN) && !redirect && (outstanding + count < DEPTH).
- A request is accepted when imem_req && imem_ready. On acceptance: pc <= pc + 8 (wraps modulo 2^AW) and outstanding increments.
- A response (imem_rvalid) decrements outstanding.
  - If drop_cnt > 0: the data is discarded and drop_cnt decrements.
  - Otherwise the bundle is pushed into the FIFO tagged with its request address. The tag is held in a parallel tag FIFO written on acceptance.
  - imem_rvalid while outstanding = 0 is ignored.
- Output: bundle_valid = (count > 0). The head fields come from the FIFO head. Opcode fields are combinational slices of the head words.
- Pop when bundle_valid && dec_ready. Simultaneous push and pop keeps count unchanged. By the credit rule a push never finds the FIFO full.
- Latency: response accepted at cycle N gives bundle_valid at N+1 (registered FIFO, no bypass).
- Redirect (highest priority after reset):
  - pc <= {redirect_pc[AW-1:3], 3'b000} and the FIFO is flushed (count = 0). A pop in the same cycle is irrelevant.
  - drop_cnt <= outstanding minus (1 if a response arrives this cycle), counted against the pre-redirect outstanding value. The arriving response is itself discarded.
  - No request is issued in the redirect cycle.
  - From HALT, redirect returns the state to RUN.
- States:
  - RUN -> HALT when halt = 1 and redirect = 0.
  - HALT -> RUN only on redirect.
  - In HALT: no requests are issued. Outstanding responses are still buffered (or dropped) and the buffer still drains to the decoder. halted = 1.
  - halt and redirect in the same cycle: redirect wins and the state is RUN.
- Tag FIFO: flushed on redirect; entries for dropped responses are popped together with the drop.
- drop_cnt never exceeds DEPTH.

Test Plan:
- Reset, imem_ready = 1, latency 1, dec_ready = 1, bundle 0x1800_0000_5000_0000 at address 0 -> imem_addr sequence 0, 8, 16.... First bundle_valid has bundle_pc = 0, R_opcode = 5'b00011, S_opcode = 5'b01010.
- dec_ready = 0 for 10 cycles -> exactly 2 requests accepted, count = 2, imem_req = 0. Release dec_ready -> bundles pop in address order 0, 8 with no loss or duplication.
- Two requests outstanding (addresses 0x10 and 0x18), redirect to 0x103 -> next imem_addr = 0x100. Both stale responses are discarded. First bundle_valid shows bundle_pc = 0x100.
- Redirect in the same cycle as a stale imem_rvalid with outstanding = 2 -> drop_cnt = 1. Exactly one further response is dropped and the following response is delivered.
- halt pulse with one request outstanding -> halted = 1, no further imem_req, pending bundle still delivered. Redirect to 0x40 -> halted = 0 and fetch resumes at 0x40.
- pc = 2^AW - 8, request accepted -> next imem_addr = 0. reset_n low during stall with count = 2 -> bundle_valid = 0 next cycle and imem_addr = RESET_PC.

Source files
------------

// File: rtl/vliw_fetch_unit.sv
// VLIW fetch stage: issues bundle reads, buffers returned bundles, splits them into R/S slots.
// Latency: a response accepted in cycle N is presented to the decoder in cycle N+1 (no bypass).
// Backpressure: requests are credit-limited so that outstanding plus buffered bundles never exceed DEPTH.
module vliw_fetch_unit #(
    parameter int              AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset_n,

    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic          imem_rvalid,
    input  logic [63:0]   imem_rdata,

    input  logic          dec_ready,
    output logic          bundle_valid,
    output logic [AW-1:0] bundle_pc,
    output logic [31:0]   r_instr,
    output logic [31:0]   s_instr,
    output logic [4:0]    R_opcode,
    output logic [4:0]    S_opcode,

    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic          halted
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW:0]   CREDITS  = (CW + 1)'(DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Circular pointer advance that also works for non power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    state_t state;
    state_t state_nxt;

    logic [AW-1:0] pc;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] outstanding;
    logic          credit_ok;

    logic          accept;
    logic          resp_fire;
    logic          resp_deliver;
    logic          buf_pop;

    // Tag FIFO: addresses of requests whose responses will still be delivered
    logic [AW-1:0] tag_mem [DEPTH];
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;
    logic [CW-1:0] tag_count;
    logic [AW-1:0] tag_head;

    // Bundle FIFO: {request address, R word, S word}
    logic [AW+63:0] buf_mem [DEPTH];
    logic [PW-1:0]  buf_wr;
    logic [PW-1:0]  buf_rd;
    logic [CW-1:0]  buf_count;
    logic [AW+63:0] buf_head;

    // Outstanding = live tagged requests plus those already condemned to be dropped.
    assign outstanding = tag_count + drop_cnt;
    assign credit_ok   = ({1'b0, outstanding} + {1'b0, buf_count}) < CREDITS;

    assign accept       = imem_req && imem_ready;
    assign resp_fire    = imem_rvalid && (outstanding != '0);
    assign resp_deliver = resp_fire && (drop_cnt == '0) && !redirect;
    assign buf_pop      = bundle_valid && dec_ready && !redirect;

    assign tag_head = tag_mem[tag_rd];
    assign buf_head = buf_mem[buf_rd];

    assign imem_addr    = pc;
    assign bundle_valid = (buf_count != '0);
    assign bundle_pc    = buf_head[AW+63:64];
    assign r_instr      = buf_head[63:32];
    assign s_instr      = buf_head[31:0];
    assign R_opcode     = r_instr[31:27];
    assign S_opcode     = s_instr[31:27];

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: redirect always restarts fetching, halt parks the unit
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (halt && !redirect) state_nxt = ST_HALT;
            ST_HALT: if (redirect)          state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs: requests only while running and credits remain, never in reset or redirect cycles
    always_comb begin
        imem_req = 1'b0;
        halted   = 1'b0;
        case (state)
            ST_RUN:  imem_req = reset_n && !redirect && credit_ok;
            ST_HALT: halted   = 1'b1;
            default: ;
        endcase
    end

    // Fetch address: redirect target is bundle aligned, otherwise advance on each accepted request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc & ~AW'(7);
        end else if (accept) begin
            pc <= pc + AW'(8);
        end
    end

    // Drop counter: on redirect every in-flight response becomes stale, minus one arriving now
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (redirect) begin
            drop_cnt <= outstanding - CW'(resp_fire);
        end else if (resp_fire && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    // Tag FIFO control: push on accepted request, pop on delivered response, flush on redirect
    always_ff @(posedge clk) begin
        if (!reset_n || redirect) begin
            tag_wr    <= '0;
            tag_rd    <= '0;
            tag_count <= '0;
        end else begin
            if (accept) begin
                tag_wr <= ptr_inc(tag_wr);
            end
            if (resp_deliver) begin
                tag_rd <= ptr_inc(tag_rd);
            end
            if (accept && !resp_deliver) begin
                tag_count <= tag_count + 1'b1;
            end else if (!accept && resp_deliver) begin
                tag_count <= tag_count - 1'b1;
            end
        end
    end

    // Tag storage: remember the address of each accepted request
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wr] <= pc;
        end
    end

    // Bundle FIFO control: push delivered responses, pop on decoder handshake, flush on redirect
    always_ff @(posedge clk) begin
        if (!reset_n || redirect) begin
            buf_wr    <= '0;
            buf_rd    <= '0;
            buf_count <= '0;
        end else begin
            if (resp_deliver) begin
                buf_wr <= ptr_inc(buf_wr);
            end
            if (buf_pop) begin
                buf_rd <= ptr_inc(buf_rd);
            end
            if (resp_deliver && !buf_pop) begin
                buf_count <= buf_count + 1'b1;
            end else if (!resp_deliver && buf_pop) begin
                buf_count <= buf_count - 1'b1;
            end
        end
    end

    // Bundle storage: tag each delivered bundle with its request address
    always_ff @(posedge clk) begin
        if (resp_deliver) begin
            buf_mem[buf_wr] <= {tag_head, imem_rdata};
        end
    end

endmodule
